mac_pipe_acc: RTL
=================

# mac_pipe_acc

Parametrised, pipelined unsigned multiply-accumulate block that sums a fixed number of products per result and delivers each sum over a valid/ready handshake. It is the sequential datapath successor to the single-cell library primitives: it is built from the flop (DFQD1-class), full/half-adder and gate cells and serves as a scalable multi-stage timing benchmark for the analyser. Width, pipeline depth and accumulation length are all generic.

## Interface
- WIDTH, 8: operand width, 2..32
- ACC_WIDTH, 20: accumulator/result width, must be >= 2*WIDTH
- STAGES, 2: multiplier pipeline register stages, 1..4
- LEN, 4: products summed per result, 1..256

- CP  in  1  clock, rising edge
- CDN  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- clear  in  1  synchronous flush of the accumulation in progress
- out_valid  out  1  result held on acc/ovf
- out_ready  in  1  consumer takes result
- acc  out  ACC_WIDTH  accumulated result
- ovf  out  1  overflow occurred while forming this result

## Operation
- Accept: in_valid && in_ready at a rising edge; the product a*b enters stage 1.
- hold = out_valid && !out_ready; in_ready = !hold (combinational). While hold, all pipeline stages, the accumulator and the term counter freeze.
- Pipeline: STAGES product registers, each with a valid bit; they advance every edge when !hold. Bubbles propagate as invalid.
- Accumulator FSM:
  - IDLE: count=0, acc_r=0.
  - ACCUM: 0<count<LEN.
  - HOLD: out_valid && !out_ready.
- On a valid product at the last stage (and !hold, !clear): sum = acc_r + product.
  - If count==LEN-1: the output register loads sum, out_valid=1, ovf=ovf_r|carry, acc_r=0, count=0, ovf_r=0.
  - Otherwise: acc_r=sum, count++, ovf_r|=carry.
- Carry means the sum exceeds 2^ACC_WIDTH-1.
- Output: on out_valid && out_ready, out_valid drops unless a new result loads at the same edge, in which case out_valid stays 1 with the new value.
- clear: clears acc_r, count, ovf_r and every pipeline valid bit. It wins over a simultaneous product arrival, which is discarded.
  - It does not touch the output register.
  - Operands accepted in the same cycle as clear are also discarded.
- Reset (CDN low, any time including mid-accumulation): all pipeline valids=0, acc_r=0, count=0, ovf_r=0, out_valid=0, acc=0, ovf=0; hence in_ready=1. Exit from reset is synchronous to CP.

## Timing
- Accept in cycle 0 -> product valid at the last stage in cycle STAGES -> out_valid in cycle STAGES+1 when it is the LEN-th term.
- Throughput: one operand pair per cycle with no bubbles while out_ready=1.
- Stall: back-pressure reaches in_ready in the same cycle (0-cycle, combinational from out_valid/out_ready only; there is no path from in_valid to in_ready).
- All outputs except in_ready are registered.

## Configuration
- MAC_SAT_EN defined: on carry the sum becomes 2^ACC_WIDTH-1 and all further terms of that result keep it saturated.
- MAC_SAT_EN undefined: the sum wraps modulo 2^ACC_WIDTH.
- ovf behaves identically in both builds.

## Structure
- Package mac_pkg holds:
  - the FSM state enum (IDLE, ACCUM, HOLD)
  - the counter width function clog2(LEN)
  - elaboration checks for the parameter ranges and ACC_WIDTH >= 2*WIDTH
- Sub-module mac_pipe_stage: one product register plus valid bit with enable (!hold) and flush (clear). It is instantiated STAGES times in a generate loop, with the multiply folded ahead of stage 1.

## Test plan
- Reset mid-run: WIDTH=8, STAGES=2, LEN=4; feed 3 terms then pulse CDN low -> out_valid=0, acc=0, in_ready=1 immediately. A following 4 terms of 1*1 -> acc=4.
- Latency: LEN=1, a=200, b=100 accepted in cycle 0 -> out_valid in cycle 3, acc=20000, ovf=0.
- Stream: LEN=4, back-to-back pairs (1,2),(3,4),(5,6),(7,8),(2,2),(2,2),(2,2),(2,2) with out_ready=1 -> results 100 then 16, consecutive and with no gaps in in_ready.
- Back-pressure: hold out_ready=0 for 5 cycles with a result pending -> in_ready=0, acc stable, no term lost. The released sequence matches the reference sums.
- Clear collision: assert clear in the cycle the 2nd of 4 products reaches the last stage -> that partial sum is discarded. The next 4 terms of 3*3 -> acc=36.
- Overflow: ACC_WIDTH=16, LEN=2, terms 255*255 twice -> ovf=1; acc=0xFFFF with MAC_SAT_EN, acc=0xFC02 (130050 mod 65536) without.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared types and elaboration helpers for the pipelined MAC.
package mac_pkg;

  // Accumulator status: IDLE (no partial sum), ACCUM (partial sum open),
  // HOLD (finished result waiting on the consumer, everything frozen).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Ceiling log2 with a floor of 1 so a LEN=1 counter still has a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Legal parameter space for mac_pipe_acc.
  function automatic bit params_ok(input int width, input int acc_width,
                                   input int stages, input int len);
    return (width >= 2) && (width <= 32) &&
           (stages >= 1) && (stages <= 4) &&
           (len >= 1) && (len <= 256) &&
           (acc_width >= 2 * width);
  endfunction

endpackage

// File: rtl/mac_pipe_stage.sv
// mac_pipe_stage: one product register with valid bit, stall enable and flush.
module mac_pipe_stage #(
  parameter int W = 16
) (
  input  logic         CP,
  input  logic         CDN,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q;
  logic [W-1:0] data_q;

  // Flush kills the valid bit even while stalled; data only moves when enabled.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (flush_i) begin
      vld_q  <= 1'b0;
    end else if (en_i) begin
      vld_q  <= vld_i;
      data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: pipelined unsigned multiply-accumulate, LEN products per result.
// Optional build macro MAC_SAT_EN: saturate the sum on carry instead of wrapping.
module mac_pipe_acc
  import mac_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20,
  parameter int STAGES    = 2,
  parameter int LEN       = 4
) (
  input  logic                 CP,
  input  logic                 CDN,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = clog2(LEN);

  if (!params_ok(WIDTH, ACC_WIDTH, STAGES, LEN)) begin : g_param_err
    $error("mac_pipe_acc: illegal WIDTH/ACC_WIDTH/STAGES/LEN combination");
  end

  acc_state_e               state;
  logic                     hold;
  logic [STAGES:0]          vld_pipe;
  logic [STAGES:0][PW-1:0]  prod_pipe;

  logic [ACC_WIDTH-1:0]     acc_q, acc_d, res_q, res_d, sum;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ovf_r_q, ovf_r_d, rovf_q, rovf_d, ov_q, ov_d;
  logic [ACC_WIDTH:0]       sum_full;
  logic                     carry, take, last;

  // Status decode; HOLD depends on the live out_ready so stall is 0-cycle.
  always_comb begin
    state = IDLE;
    if (ov_q && !out_ready) state = HOLD;
    else if (cnt_q != '0)   state = ACCUM;
  end

  assign hold     = (state == HOLD);
  assign in_ready = !hold;

  // Multiply sits ahead of stage 1; stage 0 of the arrays is the raw input.
  assign vld_pipe[0]  = in_valid && in_ready;
  assign prod_pipe[0] = PW'(a) * PW'(b);

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    mac_pipe_stage #(.W(PW)) u_stage (
      .CP      (CP),
      .CDN     (CDN),
      .en_i    (!hold),
      .flush_i (clear),
      .vld_i   (vld_pipe[s]),
      .data_i  (prod_pipe[s]),
      .vld_o   (vld_pipe[s+1]),
      .data_o  (prod_pipe[s+1])
    );
  end

  assign sum_full = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_pipe[STAGES]);
  assign carry    = sum_full[ACC_WIDTH];
  assign take     = vld_pipe[STAGES] && !hold && !clear;
  assign last     = (cnt_q == CW'(LEN - 1));

`ifdef MAC_SAT_EN
  // Once saturated, acc_q is all ones: any nonzero term carries again,
  // a zero term adds nothing, so the result stays pinned without a flag.
  assign sum = carry ? '1 : sum_full[ACC_WIDTH-1:0];
`else
  assign sum = sum_full[ACC_WIDTH-1:0];
`endif

  // Accumulator / output next state. clear beats a product arriving in the
  // same cycle and also beats hold, but never touches the output register.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_r_d = ovf_r_q;
    res_d   = res_q;
    rovf_d  = rovf_q;
    ov_d    = ov_q;
    if (ov_q && out_ready) ov_d = 1'b0;
    if (clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_r_d = 1'b0;
    end else if (take) begin
      if (last) begin
        res_d   = sum;
        rovf_d  = ovf_r_q | carry;
        ov_d    = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_r_d = 1'b0;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + CW'(1);
        ovf_r_d = ovf_r_q | carry;
      end
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_r_q <= 1'b0;
      res_q   <= '0;
      rovf_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_r_q <= ovf_r_d;
      res_q   <= res_d;
      rovf_q  <= rovf_d;
      ov_q    <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign acc       = res_q;
  assign ovf       = rovf_q;

endmodule
